// File: rtl/mod_result_accumulator.sv
// Packet accumulator: sums beats modulo q and queues {sum, beat count} per packet
// into a 2-entry output FIFO with valid/ready handshake.
module mod_result_accumulator #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] q,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_beats,
  output logic              busy
);

  // Reset asserts asynchronously and releases two clocks after rst_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  // FIFO as head register plus one second slot; the head register keeps its
  // value after a pop so outputs hold their last value while out_valid is low.
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [CNT_W-1:0]  head_beats_q, head_beats_d;
  logic              head_valid_q, head_valid_d;
  logic [DATA_W-1:0] sec_data_q, sec_data_d;
  logic [CNT_W-1:0]  sec_beats_q, sec_beats_d;
  logic              sec_valid_q, sec_valid_d;

  logic [DATA_W:0]   sum_s;
  logic [DATA_W+1:0] sub_t;
  logic [DATA_W-1:0] mod_res;
  logic [CNT_W-1:0]  cnt_inc;
  logic              accept, push, pop;

  assign in_ready  = !(head_valid_q && sec_valid_q);
  assign out_valid = head_valid_q;
  assign out_data  = head_data_q;
  assign out_beats = head_beats_q;
  assign busy      = busy_q;

  assign accept = in_valid && in_ready;
  assign push   = accept && in_last;
  assign pop    = head_valid_q && out_ready;

  always_comb begin
    sum_s   = {1'b0, acc_q} + {1'b0, in_data};
    sub_t   = {1'b0, sum_s} - {2'b00, q};
    mod_res = sub_t[DATA_W+1] ? sum_s[DATA_W-1:0] : sub_t[DATA_W-1:0];
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (accept) begin
      if (in_last) begin
        acc_d  = '0;
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        acc_d  = mod_res;
        cnt_d  = cnt_inc;
        busy_d = 1'b1;
      end
    end
  end

  always_comb begin
    head_data_d  = head_data_q;
    head_beats_d = head_beats_q;
    head_valid_d = head_valid_q;
    sec_data_d   = sec_data_q;
    sec_beats_d  = sec_beats_q;
    sec_valid_d  = sec_valid_q;
    if (sec_valid_q) begin
      // Full: no push possible, a pop promotes the second slot.
      if (pop) begin
        head_data_d  = sec_data_q;
        head_beats_d = sec_beats_q;
        sec_valid_d  = 1'b0;
      end
    end else if (head_valid_q) begin
      if (push && pop) begin
        head_data_d  = mod_res;
        head_beats_d = cnt_inc;
      end else if (push) begin
        sec_data_d   = mod_res;
        sec_beats_d  = cnt_inc;
        sec_valid_d  = 1'b1;
      end else if (pop) begin
        head_valid_d = 1'b0;
      end
    end else if (push) begin
      head_data_d  = mod_res;
      head_beats_d = cnt_inc;
      head_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      head_data_q  <= '0;
      head_beats_q <= '0;
      head_valid_q <= 1'b0;
      sec_data_q   <= '0;
      sec_beats_q  <= '0;
      sec_valid_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      head_data_q  <= head_data_d;
      head_beats_q <= head_beats_d;
      head_valid_q <= head_valid_d;
      sec_data_q   <= sec_data_d;
      sec_beats_q  <= sec_beats_d;
      sec_valid_q  <= sec_valid_d;
    end
  end

endmodule

// File: tb/tb_mod_result_accumulator.sv
// Scoreboard bench for mod_result_accumulator: expected packet results are queued
// when the last beat is accepted and compared when the FIFO head is popped.
module tb_mod_result_accumulator;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] q;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_beats;
  logic              busy;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  beats;
  } exp_t;

  exp_t        sb[$];
  longint      m_acc;
  longint      m_cnt;
  int unsigned n_total;
  int unsigned n_pass;

  mod_result_accumulator #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .q         (q),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beats (out_beats),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Monitor: a pop happens at the next posedge when valid && ready at negedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(out_data), 64'hDEAD);
      end else begin
        check("out_data", 64'(out_data), 64'(sb[0].data));
        check("out_beats", 64'(out_beats), 64'(sb[0].beats));
        void'(sb.pop_front());
      end
    end
  end

  // Called in the posedge+1 phase; returns in the same phase after acceptance.
  task automatic send(input logic [DATA_W-1:0] d, input logic last);
    int unsigned n;
    longint s;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    s = m_acc + longint'(d);
    m_acc = (s >= longint'(q)) ? s - longint'(q) : s;
    if (m_cnt < 65535) m_cnt++;
    if (last) begin
      sb.push_back('{data: m_acc[DATA_W-1:0], beats: m_cnt[CNT_W-1:0]});
      m_acc = 0;
      m_cnt = 0;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_acc = 0;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    m_acc     = 0;
    m_cnt     = 0;
    rst_n     = 1'b0;
    q         = 32'd12289;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_beats", 64'(out_beats), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    do_reset();

    // Three-beat packet with one wrap.
    send(32'd12000, 1'b0);
    check("busy_mid", 64'(busy), 64'd1);
    send(32'd300, 1'b0);
    send(32'd5, 1'b1);
    check("latency_valid", 64'(out_valid), 64'd1);
    check("busy_after", 64'(busy), 64'd0);
    drain();

    // Single beat q-1, then exact-q wrap to zero.
    send(32'd12288, 1'b1);
    send(32'd12288, 1'b0);
    send(32'd1, 1'b1);
    drain();

    // Backpressure: two entries fill the FIFO, third waits.
    out_ready = 1'b0;
    send(32'd7, 1'b1);
    send(32'd8, 1'b1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("hold_data", 64'(out_data), 64'd7);
    fork
      send(32'd9, 1'b1);
      begin
        repeat (4) @(posedge clk);
        #1;
        check("still_full", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
      end
    join
    drain();

    // Push and pop on the same edge with one entry held.
    out_ready = 1'b0;
    send(32'd20, 1'b1);
    out_ready = 1'b1;
    send(32'd21, 1'b1);
    check("pp_valid", 64'(out_valid), 64'd1);
    check("pp_head", 64'(out_data), 64'd21);
    check("pp_in_ready", 64'(in_ready), 64'd1);
    drain();

    // Reset mid-packet with an entry in the FIFO.
    out_ready = 1'b0;
    send(32'd30, 1'b1);
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    do_reset();
    out_ready = 1'b1;
    send(32'd4, 1'b0);
    send(32'd5, 1'b1);
    drain();

    // Carry out of bit DATA_W near the top of the range.
    q = 32'hFFFF_FFFB;
    send(32'hFFFF_FFFA, 1'b0);
    send(32'hFFFF_FFFA, 1'b1);
    drain();

    // Random packets under random backpressure.
    q = 32'd12289;
    fork
      begin
        for (int p = 0; p < 12; p++) begin
          int unsigned len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < int'(len); b++) begin
            send(32'($urandom_range(0, 12288)), (b == int'(len) - 1));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
          end
        end
      end
      begin
        repeat (120) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
